// File: rtl/kamus_pkg.sv
// Shared types for the kamus core: memory widths, register names and LSU control types.
package kamus_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_RSV = 2'b11
  } mem_width_e;

  typedef enum logic [4:0] {
    REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
    REG_S0, REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
    REG_A6, REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_S8, REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
  } register_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_WIDTH} lsu_err_e;

  // Decoded memory op held for the lifetime of one transaction
  typedef struct packed {
    logic            we;
    mem_width_e      width;
    logic            uns;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] wdata;
    register_e       rd;
  } lsu_op_t;

endpackage

// File: rtl/kamus_lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store replication, load extraction and
// alignment/width checks. Purely combinational.
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  mem_width_e      width,
  input  logic            uns,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            misalign_c,
  output logic            bad_width_c
);

  logic [XLEN-1:0] rdata_sh;

  always_comb begin
    be_c        = '0;
    wdata_c     = wdata;
    rdata_c     = rdata;
    misalign_c  = 1'b0;
    bad_width_c = 1'b0;
    rdata_sh    = rdata >> {addr_lo, 3'b000};
    case (width)
      MEM_B: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = uns ? {24'b0, rdata_sh[7:0]} : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      MEM_H: begin
        be_c       = 4'b0011 << addr_lo;
        wdata_c    = {2{wdata[15:0]}};
        rdata_c    = uns ? {16'b0, rdata_sh[15:0]} : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
        misalign_c = addr_lo[0];
      end
      MEM_W: begin
        be_c       = 4'b1111;
        misalign_c = (addr_lo != 2'b00);
      end
      default: bad_width_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store controller: accepts one EX memory op, runs the L1 dmem req/gnt/rvalid
// handshake with a timeout, and returns extended load data or a store ack to WB.
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_width_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [4:0]        rsp_rd_o,
  output logic [1:0]        rsp_err_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  lsu_state_e        state_q, state_d;
  lsu_op_t           op_q, op_d, op_in, op_cur;
  logic [ADDR_W-1:2] waddr_q, waddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_err_e          err_d;
  logic [31:0]       rdata_d;
  logic              timeout_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, load_c;
  logic              misalign_c, bad_width_c;

  always_comb begin
    op_in         = '0;
    op_in.we      = req_we_i;
    op_in.width   = mem_width_e'(req_width_i);
    op_in.uns     = req_unsigned_i;
    op_in.addr_lo = req_addr_i[1:0];
    op_in.wdata   = req_wdata_i;
    op_in.rd      = register_e'(req_rd_i);
  end

  // In IDLE the lane logic looks at the incoming op, afterwards at the captured one
  assign op_cur    = (state_q == IDLE) ? op_in : op_q;
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  kamus_lsu_align u_align (
    .width       (op_cur.width),
    .uns         (op_cur.uns),
    .addr_lo     (op_cur.addr_lo),
    .wdata       (op_cur.wdata),
    .rdata       (dmem_rdata_i),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .rdata_c     (load_c),
    .misalign_c  (misalign_c),
    .bad_width_c (bad_width_c)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      waddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    cnt_d   = cnt_q;
    err_d   = ERR_NONE;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = op_in;
          waddr_d = req_addr_i[ADDR_W-1:2];
          if (bad_width_c) begin
            state_d = RESP;
            err_d   = ERR_WIDTH;
          end else if (misalign_c) begin
            state_d = RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_gnt_i && dmem_rvalid_i) begin
          state_d = RESP;
          rdata_d = op_q.we ? '0 : load_c;
        end else if (dmem_gnt_i) begin
          state_d = WAIT;
        end else if (timeout_c) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          state_d = RESP;
          rdata_d = op_q.we ? '0 : load_c;
        end else if (timeout_c) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the next state so they line up with it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_rd_o     <= '0;
      rsp_err_o    <= '0;
    end else begin
      req_ready_o  <= (state_d == IDLE);
      busy_o       <= (state_d != IDLE);
      dmem_req_o   <= (state_d == REQ);
      dmem_we_o    <= (state_d == REQ) && op_cur.we;
      dmem_be_o    <= (state_d == REQ) ? be_c : 4'b0000;
      dmem_addr_o  <= (state_d == REQ) ? {waddr_d, 2'b00} : '0;
      dmem_wdata_o <= (state_d == REQ) ? wdata_c : 32'h0;
      rsp_valid_o  <= (state_d == RESP);
      rsp_rdata_o  <= rdata_d;
      rsp_rd_o     <= (state_d == RESP) ? 5'(op_cur.rd) : 5'h0;
      rsp_err_o    <= 2'(err_d);
    end
  end

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Directed bench for kamus_lsu_ctrl: vector table for single transactions plus
// hand-written sequences for combined gnt/rvalid, timeout and mid-transaction reset.
module tb_kamus_lsu_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  kamus_lsu_ctrl #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_width_i    (req_width),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_rd_i       (req_rd),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_be_o      (dmem_be),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_rd_o       (rsp_rd),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mem;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rsp_rdata;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic we, input logic [1:0] w, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [31:0] rdat,
                              input logic mem, input logic [3:0] be,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic [31:0] rr, input logic [1:0] err);
    vec_t v;
    v.we = we; v.width = w; v.uns = u; v.addr = a; v.wdata = wd; v.rd = rd;
    v.rdata = rdat; v.mem = mem; v.be = be; v.maddr = ma; v.mwdata = mwd;
    v.rsp_rdata = rr; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_width    = v.width;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_rd       = v.rd;
  endtask

  // One transaction: gnt in the first REQ cycle, rvalid the cycle after
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d_", idx);
    @(negedge clk);
    chk({p, "ready"}, 32'(req_ready), 32'd1);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.mem) begin
      chk({p, "dmem_req"}, 32'(dmem_req), 32'd1);
      chk({p, "dmem_addr"}, dmem_addr, v.maddr);
      chk({p, "dmem_be"}, 32'(dmem_be), 32'(v.be));
      chk({p, "dmem_we"}, 32'(dmem_we), 32'(v.we));
      if (v.we) chk({p, "dmem_wdata"}, dmem_wdata, v.mwdata);
      chk({p, "busy"}, 32'(busy), 32'd1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk({p, "req_drop"}, 32'(dmem_req), 32'd0);
      chk({p, "early_rsp"}, 32'(rsp_valid), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end else begin
      chk({p, "no_dmem"}, 32'(dmem_req), 32'd0);
    end
    chk({p, "rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({p, "rsp_rdata"}, rsp_rdata, v.rsp_rdata);
    chk({p, "rsp_err"}, 32'(rsp_err), 32'(v.err));
    chk({p, "rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
    @(negedge clk);
    chk({p, "rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({p, "busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    //            we    w     u     addr          wdata         rd     rdata         mem   be       maddr         mwdata        rsp_rdata     err
    vecs[0]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2'd0);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_0000, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 2'd0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        5'd8,  32'h80FF_0000, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080, 2'd0);
    vecs[3]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd3,  32'h0,        1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0,        2'd0);
    vecs[4]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0402, 32'h0,        5'd10, 32'h8001_1234, 1'b1, 4'b1100, 32'h0000_0400, 32'h0,        32'hFFFF_8001, 2'd0);
    vecs[5]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_0400, 32'h0,        5'd11, 32'h1234_F00D, 1'b1, 4'b0011, 32'h0000_0400, 32'h0,        32'h0000_F00D, 2'd0);
    vecs[6]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0305, 32'h0000_00A5, 5'd12, 32'h1111_1111, 1'b1, 4'b0010, 32'h0000_0304, 32'hA5A5_A5A5, 32'h0,        2'd0);
    vecs[7]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        5'd13, 32'h0000_7F00, 1'b1, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_007F, 2'd0);
    vecs[8]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        5'd14, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        2'd1);
    vecs[9]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,        5'd15, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        2'd1);
    vecs[10] = mk(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        5'd16, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        2'd3);
    vecs[11] = mk(1'b1, 2'd2, 1'b0, 32'h0000_07FC, 32'hCAFE_F00D, 5'd31, 32'h0,        1'b1, 4'b1111, 32'h0000_07FC, 32'hCAFE_F00D, 32'h0,        2'd0);

    rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // gnt and rvalid in the same cycle: REQ goes straight to RESP
    v = mk(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 5'd20, 32'h1234_5678, 1'b1,
           4'b1111, 32'h0000_0200, 32'h0, 32'h1234_5678, 2'd0);
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    chk("same_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("same_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("same_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("same_rsp_rd", 32'(rsp_rd), 32'd20);

    // no grant: 8 request cycles, then a timeout response
    @(negedge clk);
    v.addr = 32'h0000_0500;
    drive_req(v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("to_req%0d", i), 32'(dmem_req), 32'd1);
    end
    @(negedge clk);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd2);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_busy_resp", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_busy_fall", 32'(busy), 32'd0);
    chk("to_rsp_pulse", 32'(rsp_valid), 32'd0);

    // reset while in WAIT, then a stale rvalid must be dropped
    @(negedge clk);
    v.addr = 32'h0000_0600;
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("wr_busy_wait", 32'(busy), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    chk("wr_busy", 32'(busy), 32'd0);
    chk("wr_dmem_req", 32'(dmem_req), 32'd0);
    chk("wr_dmem_addr", dmem_addr, 32'h0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wr_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("wr_ready", 32'(req_ready), 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("wr_stale_rsp", 32'(rsp_valid), 32'd0);
    chk("wr_stale_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("wr_stale_rsp2", 32'(rsp_valid), 32'd0);
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
